mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 138 +++++++++++++
 tb/tb_mult_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHU/MULHSU.
// Magnitudes are multiplied over XLEN steps, then a single sign-fix step applies the product sign.
module mult_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            signed_a,
  input  logic            signed_b,
  input  logic            half,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]     LAST_CNT = CW'(XLEN);
  localparam logic [CW-1:0]     ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              half_q, half_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept_s;
  logic              a_neg_s, b_neg_s;
  logic [2*XLEN-1:0] fixed_acc_s;

  // Magnitude of an operand: unsigned negation wraps, so the most negative value maps to itself.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_neg);
    return is_neg ? (~v + ONE_X) : v;
  endfunction

  assign ready    = (state_q == IDLE) || (state_q == DONE);
  assign busy     = (state_q == CALC) || (state_q == SIGN);
  assign done     = (state_q == DONE);
  assign result   = result_q;

  assign accept_s    = ready & start & ~flush;
  assign a_neg_s     = signed_a & a[XLEN-1];
  assign b_neg_s     = signed_b & b[XLEN-1];
  assign fixed_acc_s = neg_q ? (~acc_q + ONE_2X) : acc_q;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    half_d   = half_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d  = CALC;
          cnt_d    = {CW{1'b0}};
          acc_d    = {(2*XLEN){1'b0}};
          mcand_d  = {{XLEN{1'b0}}, magnitude(a, a_neg_s)};
          mplier_d = magnitude(b, b_neg_s);
          half_d   = half;
          neg_d    = a_neg_s ^ b_neg_s;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // The step after the XLEN-th add only hands over to the sign stage.
        if (cnt_q == LAST_CNT) begin
          state_d = SIGN;
        end else begin
          acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + ONE_CNT;
        end
      end
      SIGN: begin
        acc_d    = fixed_acc_s;
        result_d = half_q ? fixed_acc_s[2*XLEN-1:XLEN] : fixed_acc_s[XLEN-1:0];
        state_d  = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d  = IDLE;
      cnt_d    = {CW{1'b0}};
      result_d = result_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      mcand_q  <= {(2*XLEN){1'b0}};
      mplier_q <= {XLEN{1'b0}};
      half_q   <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      half_q   <= half_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer: latency, signed/unsigned modes, flush and async reset.
module tb_mult_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_a;
  logic        signed_b;
  logic        half;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  mult_sequencer #(.XLEN(32)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .start    (start),
    .a        (a),
    .b        (b),
    .signed_a (signed_a),
    .signed_b (signed_b),
    .half     (half),
    .flush    (flush),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, let one edge accept it, then scramble the inputs.
  task automatic start_op(input logic [31:0] va, input logic [31:0] vb,
                          input logic sa, input logic sb, input logic h);
    a = va; b = vb; signed_a = sa; signed_b = sb; half = h; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    a = 32'h5A5A_A5A5; b = 32'h1234_5678; signed_a = ~sa; signed_b = ~sb; half = ~h;
  endtask

  // Count edges from acceptance until done, then check latency and result.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int found = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) begin
        found = e;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(found), 32'd34);
    chk({tag, "_result"}, result, exp);
  endtask

  initial begin
    int done_seen;
    nRST = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
    signed_a = 1'b0; signed_b = 1'b0; half = 1'b0; flush = 1'b0;
    #12;
    chk("rst_ready",  32'(ready),  32'd1);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", result,      32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // MUL signed: 7 * -3 = -21
    start_op(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0);
    chk("mul_busy", 32'(busy), 32'd1);
    chk("mul_ready", 32'(ready), 32'd0);
    wait_done("mul", 32'hFFFF_FFEB);
    @(posedge CLK); #1;
    chk("mul_done_pulse", 32'(done), 32'd0);
    chk("mul_idle_ready", 32'(ready), 32'd1);
    chk("mul_hold", result, 32'hFFFF_FFEB);

    // MULH: (-2^31)^2 = 2^62
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    wait_done("mulh", 32'h4000_0000);

    // MULHU then back-to-back MUL low half of 0xFFFFFFFF^2
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    wait_done("mulhu", 32'hFFFF_FFFE);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done("mulu_lo", 32'h0000_0001);

    // MULHSU: -1 * 0xFFFFFFFF = 0xFFFFFFFF_00000001
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    wait_done("mulhsu", 32'hFFFF_FFFF);
    @(posedge CLK); #1;

    // Flush with start held high at CALC cycle 10
    start_op(32'd100, 32'd200, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge CLK);
    #1;
    flush = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    chk("flush_busy",   32'(busy),  32'd0);
    chk("flush_ready",  32'(ready), 32'd1);
    chk("flush_done",   32'(done),  32'd0);
    chk("flush_result", result,     32'hFFFF_FFFF);
    flush = 1'b0; start = 1'b0;
    done_seen = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) done_seen++;
    end
    chk("flush_no_done", 32'(done_seen), 32'd0);
    chk("flush_keep",    result,         32'hFFFF_FFFF);

    // Zero operand still takes full latency
    start_op(32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    wait_done("zero", 32'd0);
    @(posedge CLK); #1;

    // Async reset mid-CALC, between edges
    start_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_busy",   32'(busy),  32'd0);
    chk("arst_done",   32'(done),  32'd0);
    chk("arst_ready",  32'(ready), 32'd1);
    chk("arst_result", result,     32'd0);
    #3;
    nRST = 1'b1;
    @(posedge CLK); #1;
    // Signed -6 * 9 = -54, low half
    start_op(32'hFFFF_FFFA, 32'd9, 1'b1, 1'b1, 1'b0);
    wait_done("post_rst", 32'hFFFF_FFCA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
